// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller
//
// Accepts a one-cycle load-word / store-word request from the core, issues a
// single request to a 256-entry word-addressed data memory responder, waits
// for the responder's acknowledge and, for loads, returns the read data to
// the register file with a one-cycle write strobe. Illegal requests (unknown
// opcode or address outside the 256-word window) raise a sticky error flag
// and are dropped without touching memory.
//
// Configuration:
//   LSU_TIMEOUT_EN  when defined, a WAIT-state down-counter aborts an access
//                   that has not been acknowledged within TIMEOUT cycles
//                   (mem_req drops, err sets, no write-back, no count).
//                   When undefined, WAIT lasts until mem_ack and the counter
//                   does not exist.
//
// Parameters:
//   TIMEOUT     max WAIT cycles before abort (only with LSU_TIMEOUT_EN)
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset
//   start       one-cycle request strobe from the core
//   opcode      6'b100011 load word, 6'b101011 store word
//   addr        effective word address; only 0..255 are legal
//   store_data  data to write for stores
//   busy        core stall, high whenever the controller is not IDLE
//   mem_req     request to the data memory responder
//   mem_we      1 = write, 0 = read
//   mem_addr    word index into the data memory
//   mem_wdata   write data
//   mem_ack     responder completion; read data valid in the same cycle
//   mem_rdata   read data
//   wb_en       one-cycle register-file write strobe for loads
//   wb_data     load result, valid while wb_en is high
//   err         sticky error flag, cleared only by rst
//   done_cnt    count of completed transactions (wraps)
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start; validates request
//   WAIT   | mem_req asserted, holding request until mem_ack
//   DONE   | one cycle: wb_en for loads, done_cnt increment
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [15:0] done_cnt
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  generate
    if (TIMEOUT < 1) begin : g_timeout_check
      $error("lsu_ctrl: TIMEOUT must be at least 1");
    end
  endgenerate

  state_t state;
  logic   is_load;
  logic   op_valid;
  logic   addr_ok;

  assign op_valid = (opcode == OP_LW) || (opcode == OP_SW);
  assign addr_ok  = (addr[31:8] == 24'd0);

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  // Loaded with TIMEOUT-1 on entry to WAIT; reaching zero without an ack
  // means TIMEOUT request cycles have elapsed.
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 32'd0;
      wb_en     <= 1'b0;
      wb_data   <= 32'd0;
      err       <= 1'b0;
      done_cnt  <= 16'd0;
      is_load   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // wb_en is a single-cycle strobe; it is only set on the ack edge.
      wb_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_valid && addr_ok) begin
              mem_addr  <= addr[7:0];
              mem_wdata <= store_data;
              mem_we    <= (opcode == OP_SW);
              is_load   <= (opcode == OP_LW);
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              state     <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt   <= TW'(TIMEOUT - 1);
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load) begin
              wb_data <= mem_rdata;
            end
            wb_en <= is_load;
            state <= S_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end

        S_DONE: begin
          done_cnt <= done_cnt + 16'd1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl
//
// The stimulus process pushes one expected-transaction record per accepted
// request; the monitor samples the DUT on the falling edge, attaches to a
// record when busy rises, checks the request fields every request cycle,
// the write-back data, and the completion outcome when busy falls.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int TIMEOUT = 15;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int K_NORMAL  = 0;
  localparam int K_ABORT   = 1;
  localparam int K_TIMEOUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        err;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_data    (wb_data),
    .err        (err),
    .done_cnt   (done_cnt)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        is_load;
    int          req_cyc;
    logic [15:0] cnt;
    int          kind;
  } item_t;

  item_t       q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] exp_wb  = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int n);
    int k = 0;
    while (busy && k < n) begin
      tick();
      k++;
    end
    chk("idle_wait_bound", 32'(busy), 32'd0);
  endtask

  // Full transaction: start, optional start poke while busy, ack after dly
  // wait cycles (ack lands in request cycle dly+1).
  task automatic run_txn(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         input int dly, input bit poke);
    item_t it;
    it.we      = (op == OP_SW);
    it.addr    = a[7:0];
    it.wdata   = d;
    it.is_load = (op == OP_LW);
    it.rdata   = rd;
    it.req_cyc = dly + 1;
    exp_cnt    = exp_cnt + 16'd1;
    it.cnt     = exp_cnt;
    it.kind    = K_NORMAL;
    if (op == OP_LW) exp_wb = rd;
    q.push_back(it);
    start = 1'b1; opcode = op; addr = a; store_data = d;
    tick();
    start = 1'b0; addr = 32'h0000_00EE; store_data = ~d;
    for (int i = 0; i < dly; i++) begin
      if (poke && i == 0) begin
        start = 1'b1; opcode = OP_SW; addr = a + 32'd4; store_data = 32'h1234_5678;
      end
      tick();
      start = 1'b0;
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h5555_AAAA;
    wait_idle(20);
    tick();
  endtask

  task automatic bad_req(input string nm, input logic [5:0] op, input logic [31:0] a);
    start = 1'b1; opcode = op; addr = a; store_data = 32'hBAD0_0000;
    tick();
    start = 1'b0;
    chk({nm, "_err"}, 32'(err), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_req"}, 32'(mem_req), 32'd0);
    repeat (3) tick();
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    item_t cur;
    bit    in_txn = 1'b0;
    int    reqc = 0, donec = 0, wbc = 0;
    forever begin
      @(negedge clk);
      if (!in_txn && busy === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_txn_busy", 32'(busy), 32'd0);
        end else begin
          cur = q[0];
          in_txn = 1'b1;
          reqc = 0; donec = 0; wbc = 0;
        end
      end
      if (in_txn) begin
        if (mem_req) begin
          reqc++;
          chk("req_addr", 32'(mem_addr), 32'(cur.addr));
          chk("req_we", 32'(mem_we), 32'(cur.we));
          chk("req_wdata", mem_wdata, cur.wdata);
        end else if (busy) begin
          donec++;
        end
        if (wb_en) begin
          wbc++;
          chk("wb_data", wb_data, cur.rdata);
        end
        if (!busy) begin
          case (cur.kind)
            K_NORMAL: begin
              chk("req_cycles", 32'(reqc), 32'(cur.req_cyc));
              chk("done_cycles", 32'(donec), 32'd1);
              chk("wb_pulses", 32'(wbc), cur.is_load ? 32'd1 : 32'd0);
              chk("done_cnt", 32'(done_cnt), 32'(cur.cnt));
            end
            K_ABORT: begin
              chk("abort_wb_pulses", 32'(wbc), 32'd0);
              chk("abort_req", 32'(mem_req), 32'd0);
              chk("abort_done_cnt", 32'(done_cnt), 32'(cur.cnt));
            end
            default: begin
              chk("tmo_req_cycles", 32'(reqc), 32'(cur.req_cyc));
              chk("tmo_wb_pulses", 32'(wbc), 32'd0);
              chk("tmo_err", 32'(err), 32'd1);
              chk("tmo_done_cnt", 32'(done_cnt), 32'(cur.cnt));
            end
          endcase
          void'(q.pop_front());
          in_txn = 1'b0;
        end
      end else if (mem_req === 1'b1 || wb_en === 1'b1) begin
        chk("spurious_req", 32'(mem_req), 32'd0);
        chk("spurious_wb", 32'(wb_en), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    item_t it;
    rst = 1'b1; start = 1'b0; opcode = 6'd0; addr = 32'd0; store_data = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    tick();

    run_txn(OP_LW, 32'd5,    32'h0000_0000, 32'hDEAD_BEEF, 1, 1'b0);
    chk("load1_wb_hold", wb_data, 32'hDEAD_BEEF);
    run_txn(OP_SW, 32'd3,    32'h0000_0040, 32'hFFFF_0000, 3, 1'b0);
    chk("store_wb_untouched", wb_data, 32'hDEAD_BEEF);
    run_txn(OP_LW, 32'd255,  32'h0000_0011, 32'h1234_5678, 0, 1'b0);
    run_txn(OP_SW, 32'd0,    32'hA5A5_5A5A, 32'h0000_0000, 2, 1'b0);

    bad_req("bad_opcode", 6'b000000, 32'd4);
    bad_req("bad_addr", OP_LW, 32'h0000_0100);
    run_txn(OP_LW, 32'd17,   32'h0000_0000, 32'hC0FF_EE00, 1, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);

    run_txn(OP_LW, 32'd7,    32'h0000_0000, 32'h0BAD_F00D, 4, 1'b1);
    chk("interlock_cnt", 32'(done_cnt), 32'(exp_cnt));

    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_wb_data", wb_data, exp_wb);
    chk("idle_ack_cnt", 32'(done_cnt), 32'(exp_cnt));

    // Reset in the middle of WAIT, with a simultaneous ack
    it.we = 1'b1; it.addr = 8'd10; it.wdata = 32'h0000_0099; it.rdata = 32'd0;
    it.is_load = 1'b0; it.req_cyc = 0; it.cnt = 16'd0; it.kind = K_ABORT;
    q.push_back(it);
    start = 1'b1; opcode = OP_SW; addr = 32'd10; store_data = 32'h0000_0099;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    start = 1'b1; opcode = OP_LW; addr = 32'd1;
    tick();
    rst = 1'b0; mem_ack = 1'b0; start = 1'b0;
    exp_cnt = 16'd0; exp_wb = 32'd0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_cnt_now", 32'(done_cnt), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    tick();
    chk("abort_no_wb", 32'(wb_en), 32'd0);

    // Preload the completion counter to exercise the wrap
    force dut.done_cnt = 16'hFFFF;
    tick();
    release dut.done_cnt;
    tick();
    exp_cnt = 16'hFFFF;
    chk("preload_cnt", 32'(done_cnt), 32'h0000_FFFF);
    run_txn(OP_LW, 32'd42, 32'h0000_0000, 32'h0000_0001, 1, 1'b0);
    chk("wrap_cnt", 32'(done_cnt), 32'd0);

    // Never-acknowledged request
    it.we = 1'b0; it.addr = 8'h20; it.wdata = 32'h0000_0000; it.rdata = 32'd0;
    it.is_load = 1'b1; it.req_cyc = TIMEOUT;
`ifdef LSU_TIMEOUT_EN
    it.cnt = exp_cnt; it.kind = K_TIMEOUT;
`else
    it.cnt = 16'd0; it.kind = K_ABORT;
`endif
    q.push_back(it);
    start = 1'b1; opcode = OP_LW; addr = 32'h20; store_data = 32'h0000_0000;
    tick();
    start = 1'b0;
`ifdef LSU_TIMEOUT_EN
    wait_idle(TIMEOUT + 5);
    chk("tmo_err_now", 32'(err), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("tmo_late_ack_cnt", 32'(done_cnt), 32'(exp_cnt));
    chk("tmo_late_ack_busy", 32'(busy), 32'd0);
`else
    repeat (40) tick();
    chk("noack_busy", 32'(busy), 32'd1);
    chk("noack_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 16'd0;
    tick();
`endif

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
